// File: rtl/frog_game_ctrl_if.sv
// Game-control bus between the frog playfield logic and the game controller.
// Master drives keyboard and collision flags; slave returns game status.
interface frog_game_ctrl_if;
   logic [15:0] keycode;
   logic        car_hit;
   logic        in_water;
   logic        on_platform;
   logic        goal_reached;
   logic        frogreset;
   logic        stage1x;
   logic        stage2x;
   logic [3:0]  lives;
   logic [7:0]  score;
   logic        dying;
   logic        game_over;
   logic [10:0] time_left;

   modport master (
      output keycode, car_hit, in_water, on_platform, goal_reached,
      input  frogreset, stage1x, stage2x, lives, score, dying, game_over, time_left
   );

   modport slave (
      input  keycode, car_hit, in_water, on_platform, goal_reached,
      output frogreset, stage1x, stage2x, lives, score, dying, game_over, time_left
   );
endinterface

// File: rtl/frog_game_ctrl.sv
// Frogger game sequencer: start/respawn/play/death/level-up/game-over flow.
// Define FROG_TIMER_EN to add the per-life countdown timer.
module frog_game_ctrl #(
   parameter int START_LIVES  = 3,
   parameter int DEATH_FRAMES = 30,
   parameter int GOAL_FRAMES  = 60,
   parameter int TIME_FRAMES  = 1800
) (
   input  logic             frame_clk,
   input  logic             Reset,
   frog_game_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {IDLE, RESPAWN, PLAY, DYING, LEVELUP, OVER} state_t;

   state_t      state;
   logic        level_two;
   logic [15:0] prev_key;
   logic [15:0] counter;
   logic        start;
   logic        timeout;
   logic        death;

   // Start is a key-press edge so a held key cannot restart the game.
   assign start = (bus.keycode == 16'h0028) && (prev_key != 16'h0028);
   assign death = bus.car_hit | (bus.in_water & ~bus.on_platform) | timeout;

`ifdef FROG_TIMER_EN
   logic [10:0] time_q;

   // Reloads during the respawn frame; timeout fires on the frame it would reach zero.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         time_q <= '0;
      end else if (state == RESPAWN) begin
         time_q <= 11'(TIME_FRAMES);
      end else if (state == PLAY && time_q != 11'd0) begin
         time_q <= time_q - 11'd1;
      end
   end

   assign timeout       = (time_q <= 11'd1);
   assign bus.time_left = time_q;
`else
   assign timeout       = 1'b0;
   assign bus.time_left = '0;
`endif

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state         <= IDLE;
         level_two     <= 1'b0;
         prev_key      <= '0;
         counter       <= '0;
         bus.lives     <= 4'(START_LIVES);
         bus.score     <= '0;
         bus.frogreset <= 1'b0;
         bus.stage1x   <= 1'b0;
         bus.stage2x   <= 1'b0;
         bus.dying     <= 1'b0;
         bus.game_over <= 1'b0;
      end else begin
         prev_key      <= bus.keycode;
         bus.frogreset <= 1'b0;
         case (state)
            IDLE, OVER: begin
               if (start) begin
                  state         <= RESPAWN;
                  level_two     <= 1'b0;
                  bus.lives     <= 4'(START_LIVES);
                  bus.score     <= '0;
                  bus.game_over <= 1'b0;
                  bus.frogreset <= 1'b1;
               end
            end
            RESPAWN: begin
               state       <= PLAY;
               bus.stage1x <= ~level_two;
               bus.stage2x <= level_two;
            end
            // Death outranks a simultaneous goal so a fatal crossing never scores.
            PLAY: begin
               if (death) begin
                  state       <= DYING;
                  bus.lives   <= (bus.lives == 4'd0) ? 4'd0 : bus.lives - 4'd1;
                  counter     <= 16'(DEATH_FRAMES - 1);
                  bus.dying   <= 1'b1;
                  bus.stage1x <= 1'b0;
                  bus.stage2x <= 1'b0;
               end else if (bus.goal_reached) begin
                  state       <= LEVELUP;
                  bus.score   <= (bus.score == 8'd255) ? 8'd255 : bus.score + 8'd1;
                  counter     <= 16'(GOAL_FRAMES - 1);
                  bus.stage1x <= 1'b0;
                  bus.stage2x <= 1'b0;
               end
            end
            DYING: begin
               if (counter == 16'd0) begin
                  bus.dying <= 1'b0;
                  if (bus.lives == 4'd0) begin
                     state         <= OVER;
                     bus.game_over <= 1'b1;
                  end else begin
                     state         <= RESPAWN;
                     bus.frogreset <= 1'b1;
                  end
               end else begin
                  counter <= counter - 16'd1;
               end
            end
            // Completing level 2 wraps back to level 1 and awards a bonus life.
            LEVELUP: begin
               if (counter == 16'd0) begin
                  level_two     <= ~level_two;
                  if (level_two && bus.lives < 4'd9) bus.lives <= bus.lives + 4'd1;
                  state         <= RESPAWN;
                  bus.frogreset <= 1'b1;
               end else begin
                  counter <= counter - 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Directed testbench for frog_game_ctrl; timer scenario runs in FROG_TIMER_EN builds.
module tb_frog_game_ctrl;

   logic frame_clk = 1'b0;
   logic Reset     = 1'b1;
   int   total     = 0;
   int   bad       = 0;
   int   n;
   int   d;

   always #5 frame_clk = ~frame_clk;

   frog_game_ctrl_if bus();
   frog_game_ctrl dut (.frame_clk(frame_clk), .Reset(Reset), .bus(bus.slave));

`ifdef FROG_TIMER_EN
   frog_game_ctrl_if tbus();
   frog_game_ctrl #(.TIME_FRAMES(5)) tdut (.frame_clk(frame_clk), .Reset(Reset), .bus(tbus.slave));
`endif

   task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] key, input logic car, input logic water,
                                input logic plat, input logic goal);
      bus.keycode      = key;
      bus.car_hit      = car;
      bus.in_water     = water;
      bus.on_platform  = plat;
      bus.goal_reached = goal;
      @(posedge frame_clk);
      #1;
   endtask

   // Counts frames until the respawn pulse and how many of them still showed dying.
   task automatic waitRespawn(input logic [15:0] key, output int frames, output int dying_frames);
      frames = 0;
      dying_frames = 0;
      do begin
         applyStimulus(key, 1'b0, 1'b0, 1'b0, 1'b0);
         frames++;
         if (bus.dying) dying_frames++;
      end while (!bus.frogreset && frames < 200);
   endtask

   initial begin
      bus.keycode = '0; bus.car_hit = 0; bus.in_water = 0; bus.on_platform = 0; bus.goal_reached = 0;
`ifdef FROG_TIMER_EN
      tbus.keycode = '0; tbus.car_hit = 0; tbus.in_water = 0; tbus.on_platform = 0; tbus.goal_reached = 0;
`endif
      repeat (2) @(posedge frame_clk);
      #1;
      checkOutput("rst_lives", 16'(bus.lives), 3);
      checkOutput("rst_score", 16'(bus.score), 0);
      checkOutput("rst_frogreset", 16'(bus.frogreset), 0);
      checkOutput("rst_stage1x", 16'(bus.stage1x), 0);
      checkOutput("rst_dying", 16'(bus.dying), 0);
      checkOutput("rst_game_over", 16'(bus.game_over), 0);
      checkOutput("rst_time_left", 16'(bus.time_left), 0);
      Reset = 1'b0;

      applyStimulus(16'h0028, 0, 0, 0, 0);
      checkOutput("start_frogreset", 16'(bus.frogreset), 1);
      checkOutput("start_lives", 16'(bus.lives), 3);
      applyStimulus(16'h0000, 0, 0, 0, 0);
      checkOutput("play_stage1x", 16'(bus.stage1x), 1);
      checkOutput("play_stage2x", 16'(bus.stage2x), 0);
      checkOutput("play_frogreset", 16'(bus.frogreset), 0);

      applyStimulus(16'h0000, 0, 0, 0, 1);
      checkOutput("goal1_score", 16'(bus.score), 1);
      checkOutput("goal1_stage1x", 16'(bus.stage1x), 0);
      waitRespawn(16'h0000, n, d);
      checkOutput("goal1_frames", 16'(n), 60);
      applyStimulus(16'h0000, 0, 0, 0, 0);
      checkOutput("lvl2_stage2x", 16'(bus.stage2x), 1);
      checkOutput("lvl2_stage1x", 16'(bus.stage1x), 0);
      checkOutput("lvl2_lives", 16'(bus.lives), 3);

      applyStimulus(16'h0000, 0, 0, 0, 1);
      checkOutput("goal2_score", 16'(bus.score), 2);
      waitRespawn(16'h0000, n, d);
      checkOutput("goal2_frames", 16'(n), 60);
      checkOutput("goal2_lives", 16'(bus.lives), 4);
      applyStimulus(16'h0000, 0, 0, 0, 0);
      checkOutput("lvl1_stage1x", 16'(bus.stage1x), 1);

      applyStimulus(16'h0000, 0, 1, 1, 0);
      checkOutput("platform_safe", 16'(bus.dying), 0);
      applyStimulus(16'h0000, 0, 1, 0, 0);
      checkOutput("water_dying", 16'(bus.dying), 1);
      checkOutput("water_lives", 16'(bus.lives), 3);
      checkOutput("water_stage1x", 16'(bus.stage1x), 0);
      waitRespawn(16'h0000, n, d);
      checkOutput("water_frames", 16'(n), 30);
      checkOutput("water_dying_frames", 16'(d), 29);
      checkOutput("water_dying_end", 16'(bus.dying), 0);
      applyStimulus(16'h0000, 0, 0, 0, 0);

      applyStimulus(16'h0000, 1, 0, 0, 1);
      checkOutput("both_dying", 16'(bus.dying), 1);
      checkOutput("both_score", 16'(bus.score), 2);
      checkOutput("both_lives", 16'(bus.lives), 2);
      applyStimulus(16'h0000, 0, 0, 0, 1);
      checkOutput("goal_ignored_dying", 16'(bus.score), 2);
      waitRespawn(16'h0000, n, d);
      checkOutput("both_frames", 16'(n), 29);
      applyStimulus(16'h0000, 0, 0, 0, 0);

      applyStimulus(16'h0000, 1, 0, 0, 0);
      checkOutput("car_lives", 16'(bus.lives), 1);
      waitRespawn(16'h0000, n, d);
      applyStimulus(16'h0000, 0, 0, 0, 0);

      // Last death with the start key held through entry into OVER.
      applyStimulus(16'h0028, 1, 0, 0, 0);
      checkOutput("last_lives", 16'(bus.lives), 0);
      n = 0;
      do begin
         applyStimulus(16'h0028, 0, 0, 0, 0);
         n++;
      end while (!bus.game_over && n < 100);
      checkOutput("over_frames", 16'(n), 30);
      checkOutput("over_game_over", 16'(bus.game_over), 1);
      repeat (3) applyStimulus(16'h0028, 0, 0, 0, 0);
      checkOutput("held_no_restart", 16'(bus.frogreset), 0);
      checkOutput("held_game_over", 16'(bus.game_over), 1);
      applyStimulus(16'h0000, 0, 0, 0, 0);
      applyStimulus(16'h0028, 0, 0, 0, 0);
      checkOutput("restart_frogreset", 16'(bus.frogreset), 1);
      checkOutput("restart_game_over", 16'(bus.game_over), 0);
      checkOutput("restart_lives", 16'(bus.lives), 3);
      checkOutput("restart_score", 16'(bus.score), 0);
      applyStimulus(16'h0000, 0, 0, 0, 0);
      checkOutput("restart_stage1x", 16'(bus.stage1x), 1);

      applyStimulus(16'h0000, 1, 0, 0, 0);
      checkOutput("abort_dying_pre", 16'(bus.dying), 1);
      Reset = 1'b1;
      #2;
      checkOutput("abort_dying", 16'(bus.dying), 0);
      checkOutput("abort_lives", 16'(bus.lives), 3);
      checkOutput("abort_stage1x", 16'(bus.stage1x), 0);
      @(posedge frame_clk);
      #1;
      Reset = 1'b0;

`ifdef FROG_TIMER_EN
      tbus.keycode = 16'h0028;
      @(posedge frame_clk); #1;
      tbus.keycode = 16'h0000;
      @(posedge frame_clk); #1;
      checkOutput("timer_load", 16'(tbus.time_left), 5);
      n = 1;
      do begin
         @(posedge frame_clk); #1;
         if (tbus.stage1x) n++;
      end while (tbus.stage1x && n < 50);
      checkOutput("timer_play_frames", 16'(n), 5);
      checkOutput("timer_dying", 16'(tbus.dying), 1);
      checkOutput("timer_lives", 16'(tbus.lives), 2);
      n = 0;
      do begin
         @(posedge frame_clk); #1;
         n++;
      end while (!tbus.frogreset && n < 100);
      @(posedge frame_clk); #1;
      checkOutput("timer_reload", 16'(tbus.time_left), 5);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
